// File: rtl/shield_controller.sv
// shield_controller: per-player shield meter sequencer and hit arbiter.
// The meter drains while shielding, waits after release, then regenerates
// to full. An empty meter locks the shield out for a fixed number of ticks.
// Hits use a four-phase req/ack handshake. A hit is absorbed only when it is
// accepted while the controller is in HOLD.
module shield_controller #(
  parameter int unsigned MAX_SHIELD    = 15,
  parameter int unsigned DRAIN         = 1,
  parameter int unsigned HIT_COST      = 4,
  parameter int unsigned REGEN_DELAY   = 2,
  parameter int unsigned BREAK_LOCKOUT = 6
) (
  input  logic       slowed_shield_clk,
  input  logic       reset,
  input  logic       shield_btn,
  input  logic       hit_req,
  output logic [3:0] shield,
  output logic       shield_active,
  output logic       broken,
  output logic       hit_ack,
  output logic       hit_absorbed
);

  localparam logic [3:0] MAX_S     = 4'(MAX_SHIELD);
  localparam logic [4:0] DRAIN_5   = 5'(DRAIN);
  localparam logic [4:0] HIT_5     = 5'(HIT_COST);
  localparam logic [3:0] DELAY_CNT = 4'(REGEN_DELAY);
  localparam logic [3:0] LOCK_CNT  = 4'(BREAK_LOCKOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HOLD   = 3'd1,
    S_DELAY  = 3'd2,
    S_REGEN  = 3'd3,
    S_BROKEN = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] shield_q, shield_d;
  logic [3:0] cnt_q, cnt_d;
  logic       shield_active_q, shield_active_d;
  logic       broken_q, broken_d;
  logic       hit_ack_q, hit_ack_d;
  logic       hit_absorbed_q, hit_absorbed_d;
  logic       hit_accept;
  logic [4:0] sub;
  logic [4:0] diff;

  // Next-state, meter arithmetic and handshake decode.
  always_comb begin
    state_d         = state_q;
    shield_d        = shield_q;
    cnt_d           = cnt_q;
    sub             = 5'd0;
    diff            = 5'd0;
    hit_accept      = hit_req && !hit_ack_q;

    case (state_q)
      S_IDLE: begin
        if (shield_btn) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        // 5-bit math so a cost larger than the meter floors at 0 instead of wrapping.
        sub = (shield_btn ? DRAIN_5 : 5'd0) + (hit_accept ? HIT_5 : 5'd0);
        if ({1'b0, shield_q} > sub) begin
          diff = {1'b0, shield_q} - sub;
        end else begin
          diff = 5'd0;
        end
        shield_d = diff[3:0];
        if (diff == 5'd0) begin
          state_d = S_BROKEN;
          cnt_d   = LOCK_CNT;
        end else if (!shield_btn) begin
          state_d = S_DELAY;
          cnt_d   = DELAY_CNT;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DELAY: begin
        if (shield_btn && (shield_q != 4'd0)) begin
          state_d = S_HOLD;
        end else if (cnt_q == 4'd1) begin
          state_d = S_REGEN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_REGEN: begin
        if (shield_btn && (shield_q != 4'd0)) begin
          state_d = S_HOLD;
        end else if (({1'b0, shield_q} + 5'd1) >= {1'b0, MAX_S}) begin
          shield_d = MAX_S;
          state_d  = S_IDLE;
        end else begin
          shield_d = shield_q + 4'd1;
        end
      end
      S_BROKEN: begin
        shield_d = 4'd0;
        if (cnt_q == 4'd1) begin
          state_d = S_REGEN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        shield_d = MAX_S;
        cnt_d    = 4'd0;
      end
    endcase

    // Once acked, only a drop of hit_req matters; when idle, a request is accepted.
    if (hit_ack_q) begin
      hit_ack_d = hit_req;
    end else begin
      hit_ack_d = hit_accept;
    end

    if (hit_accept) begin
      hit_absorbed_d = (state_q == S_HOLD);
    end else begin
      hit_absorbed_d = hit_absorbed_q;
    end

    shield_active_d = (state_d == S_HOLD);
    broken_d        = (state_d == S_BROKEN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge slowed_shield_clk) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      shield_q        <= MAX_S;
      cnt_q           <= 4'd0;
      shield_active_q <= 1'b0;
      broken_q        <= 1'b0;
      hit_ack_q       <= 1'b0;
      hit_absorbed_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      shield_q        <= shield_d;
      cnt_q           <= cnt_d;
      shield_active_q <= shield_active_d;
      broken_q        <= broken_d;
      hit_ack_q       <= hit_ack_d;
      hit_absorbed_q  <= hit_absorbed_d;
    end
  end

  assign shield        = shield_q;
  assign shield_active = shield_active_q;
  assign broken        = broken_q;
  assign hit_ack       = hit_ack_q;
  assign hit_absorbed  = hit_absorbed_q;

endmodule

// File: tb/tb_shield_controller.sv
// Directed vector bench for shield_controller with default parameters.
module tb_shield_controller;

  logic       clk;
  logic       reset;
  logic       shield_btn;
  logic       hit_req;
  logic [3:0] shield;
  logic       shield_active;
  logic       broken;
  logic       hit_ack;
  logic       hit_absorbed;

  int n_vec;
  int n_err;

  typedef struct {
    logic       rst;
    logic       btn;
    logic       req;
    logic [3:0] sh;
    logic       act;
    logic       brk;
    logic       ack;
    logic       abs_f;
  } vec_t;

  vec_t vq[$];

  shield_controller dut (
    .slowed_shield_clk (clk),
    .reset             (reset),
    .shield_btn        (shield_btn),
    .hit_req           (hit_req),
    .shield            (shield),
    .shield_active     (shield_active),
    .broken            (broken),
    .hit_ack           (hit_ack),
    .hit_absorbed      (hit_absorbed)
  );

  // Free-running tick clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic add(input logic rst, input logic btn, input logic req,
                     input int sh, input logic act, input logic brk,
                     input logic ack, input logic abs_f);
    vec_t v;
    v.rst = rst; v.btn = btn; v.req = req; v.sh = 4'(sh);
    v.act = act; v.brk = brk; v.ack = ack; v.abs_f = abs_f;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int i;
    int nb;
    reset      = 1'b0;
    shield_btn = 1'b0;
    hit_req    = 1'b0;
    n_vec      = 0;
    n_err      = 0;

    // rst btn req | shield act brk ack abs
    add(0, 0, 0, 15, 0, 0, 0, 0);
    add(1, 0, 0, 15, 0, 0, 0, 0);
    // drain 6 ticks, release, delay, regen to full
    for (int k = 0; k < 6; k++) add(1, 1, 0, 15 - k, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 0, 10, 0, 0, 0, 0);
    for (int k = 11; k <= 15; k++) add(1, 0, 0, k, 0, 0, 0, 0);
    add(1, 0, 0, 15, 0, 0, 0, 0);
    // unabsorbed hit during regen at shield 8
    for (int k = 0; k < 9; k++) add(1, 1, 0, 15 - k, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 0, 7, 0, 0, 0, 0);
    add(1, 0, 0, 8, 0, 0, 0, 0);
    add(1, 0, 1, 9, 0, 0, 1, 0);
    add(1, 0, 1, 10, 0, 0, 1, 0);
    add(1, 0, 1, 11, 0, 0, 1, 0);
    add(1, 0, 0, 12, 0, 0, 0, 0);
    for (int k = 13; k <= 15; k++) add(1, 0, 0, k, 0, 0, 0, 0);
    add(1, 0, 0, 15, 0, 0, 0, 0);
    // absorbed hit in HOLD at shield 5 breaks the meter
    for (int k = 0; k < 11; k++) add(1, 1, 0, 15 - k, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 1, 1, 1);
    for (int k = 0; k < 5; k++) add(1, 1, 0, 0, 0, 1, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 1, 0, 0, 0, 1);
    add(1, 1, 0, 1, 1, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 0, 1);
    add(1, 1, 0, 1, 1, 0, 0, 1);
    // hit and release on the same HOLD tick floors at 0
    add(1, 0, 1, 0, 0, 1, 1, 1);
    // reset mid-handshake, then request re-presented in IDLE
    add(0, 1, 1, 15, 0, 0, 0, 0);
    add(1, 0, 1, 15, 0, 0, 1, 0);
    add(1, 0, 0, 15, 0, 0, 0, 0);
    // hit and release on the same tick without breaking
    add(1, 1, 0, 15, 1, 0, 0, 0);
    add(1, 1, 0, 14, 1, 0, 0, 0);
    add(1, 0, 1, 10, 0, 0, 1, 1);
    add(1, 0, 0, 10, 0, 0, 0, 1);
    add(1, 0, 0, 10, 0, 0, 0, 1);
    add(1, 0, 0, 11, 0, 0, 0, 1);

    foreach (vq[j]) begin
      vec_t v;
      logic [7:0] got, exp;
      v = vq[j];
      reset      = v.rst;
      shield_btn = v.btn;
      hit_req    = v.req;
      tick();
      got = {shield, shield_active, broken, hit_ack, hit_absorbed};
      exp = {v.sh, v.act, v.brk, v.ack, v.abs_f};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL vec%0d: got sh=%0d act=%b brk=%b ack=%b abs=%b expected sh=%0d act=%b brk=%b ack=%b abs=%b",
                 j, shield, shield_active, broken, hit_ack, hit_absorbed,
                 v.sh, v.act, v.brk, v.ack, v.abs_f);
      end
    end

    // Break timeline with the button held from full.
    reset = 1'b0; shield_btn = 1'b0; hit_req = 1'b0;
    tick();
    reset = 1'b1; shield_btn = 1'b1;
    i = 0;
    while (i < 40) begin
      i++;
      tick();
      if (broken) break;
    end
    check("break_tick", i, 16);
    check("break_shield", int'(shield), 0);
    nb = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (broken) nb++;
      else break;
    end
    check("lockout_len", nb, 6);
    check("regen_entry_shield", int'(shield), 0);
    tick();
    check("regen_first_inc", int'(shield), 1);
    check("regen_active", int'(shield_active), 0);
    tick();
    check("reshield_active", int'(shield_active), 1);
    check("reshield_shield", int'(shield), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shield_controller.md
# shield_controller

Per-player shield meter controller, clocked by the 2 Hz slowed shield clock. It sequences drain while shielding, a regen delay after release, regeneration back to full, and a lockout when the meter breaks. It also arbitrates incoming hits from the game logic with a four-phase req/ack handshake, reporting whether each hit was absorbed by the shield. It feeds `shield` and `shield_active` to the player action logic and the sprite/HUD renderer.

## Interface
- MAX_SHIELD, 15: full meter value; also the reset value; 1..15.
- DRAIN, 1: meter units removed per tick while shielding.
- HIT_COST, 4: extra units removed by an absorbed hit.
- REGEN_DELAY, 2: ticks spent in DELAY after release; 1..15.
- BREAK_LOCKOUT, 6: ticks spent in BROKEN; 1..15.

Ports:
- slowed_shield_clk  in  1  2 Hz tick clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low.
- shield_btn  in  1  level; player holding shield.
- hit_req  in  1  level; game requests hit resolution and holds it until it sees hit_ack=1.
- shield  out  4  current meter value.
- shield_active  out  1  high in HOLD only.
- broken  out  1  high in BROKEN only.
- hit_ack  out  1  handshake acknowledge.
- hit_absorbed  out  1  result of the last acknowledged hit; valid while hit_ack=1, held until the next ack.

## Operation
- States: IDLE (meter full), HOLD, DELAY, REGEN, BROKEN. A 4-bit tick counter `cnt` serves DELAY and BROKEN.
- Reset (reset=0 at an edge) sets:
  - state=IDLE, shield=MAX_SHIELD, cnt=0.
  - shield_active=0, broken=0, hit_ack=0, hit_absorbed=0.
- **IDLE**
  - If shield_btn: go to HOLD; shield is unchanged on the entry tick.
- **HOLD** — compute sub = (shield_btn ? DRAIN : 0) + (hit accepted this tick ? HIT_COST : 0).
  - shield <= saturating shield−sub, floored at 0. Use a 5-bit intermediate so there is no wrap.
  - If the result is 0: go to BROKEN, cnt=BREAK_LOCKOUT. This takes priority over everything else.
  - Else if !shield_btn: go to DELAY, cnt=REGEN_DELAY.
  - Else stay in HOLD.
- **DELAY**
  - If shield_btn and shield>0: go to HOLD.
  - Else if cnt==1: go to REGEN.
  - Else cnt−1.
  - DELAY therefore lasts exactly REGEN_DELAY ticks if the button stays released.
- **REGEN**
  - If shield_btn and shield>0: go to HOLD, with no increment on that tick.
  - Else shield+1; if shield+1==MAX_SHIELD go to IDLE.
- **BROKEN**
  - shield_btn is ignored and shield stays 0.
  - If cnt==1: go to REGEN; else cnt−1. BROKEN lasts exactly BREAK_LOCKOUT ticks.
- **Hit handshake** (four-phase):
  - Acceptance: a hit is accepted on a tick where hit_req=1 and hit_ack=0. On that tick hit_ack<=1 and hit_absorbed<=(state==HOLD at that edge).
  - Absorbed hit: costs HIT_COST, applied via the HOLD rule above.
  - Hit outside HOLD: not absorbed, and shield is unchanged.
  - While hit_ack=1: hit_req is not re-sampled. When hit_req=0 is seen, hit_ack<=0 on that edge.
  - Next acceptance: a new hit can be accepted no earlier than the following tick.
- shield_active and broken are decoded from the registered state, so there is no combinational path from inputs.

## Timing
- Latency: every input takes effect on the first rising edge at which it is sampled. Outputs update at that edge.
- The first drain occurs on the tick after entering HOLD, so the first decrement is 1 tick (0.5 s) after the press is sampled.
- Timeline from full to broken with shield_btn held and DRAIN=1: 1 entry tick + 15 drain ticks. The HOLD→BROKEN transition and shield=0 occur on the same edge.
- Hit and release on the same HOLD tick: the hit cost is applied with no drain, then the block goes to DELAY (or to BROKEN if the result is 0).
- Reset mid-handshake: hit_ack drops to 0. The game must re-present the request.
- Reset overrides all other inputs on the same edge.
- Inputs come from the fast domain as slow-changing levels. No pulse inputs are permitted.

## Test plan
- **Reset.** reset=0 for 1 tick → shield=15, state IDLE, all flags 0.
- **Drain, release, regen.** Hold shield_btn 6 ticks from full, then release.
  - shield_active=1 for ticks 1–6, shield=10.
  - DELAY for 2 ticks with shield=10.
  - REGEN reaches 15 after 5 more ticks, then IDLE.
- **Break and lockout.** Hold shield_btn continuously.
  - shield hits 0 on tick 16 and broken=1 for exactly 6 ticks while the button is still held.
  - Then REGEN with shield=1, then HOLD on the next tick.
- **Absorbed hit.** In HOLD with shield=5, assert hit_req.
  - hit_ack=1, hit_absorbed=1, shield=0 (5−1−4), broken=1 on the same edge.
  - Drop hit_req → hit_ack=0 on the next tick.
- **Unabsorbed hit.** In REGEN with shield=8, assert hit_req.
  - hit_ack=1, hit_absorbed=0, shield becomes 9 (regen continues).
  - Hold hit_req 3 ticks → only one acceptance.
- **Re-shield and reset in flight.** Press shield_btn during DELAY with shield=3 → HOLD next edge, cnt is ignored. Assert reset with hit_ack=1 → all outputs return to reset values.
